// File: rtl/hdmi_period_scheduler_if.sv
// Bundle of raster/period outputs and the packet-source handshake for hdmi_period_scheduler.
// master: the scheduler side. slave: packet source / TMDS encoder side.
interface hdmi_period_scheduler_if;
  logic        pkt_valid;
  logic        pkt_start;
  logic [4:0]  island_word;
  logic [2:0]  mode;
  logic [1:0]  ctl_ch0;
  logic [1:0]  ctl_ch1;
  logic [1:0]  ctl_ch2;
  logic [11:0] cx;
  logic [11:0] cy;
  logic        hsync;
  logic        vsync;

  modport master (
    input  pkt_valid,
    output pkt_start, island_word, mode, ctl_ch0, ctl_ch1, ctl_ch2, cx, cy, hsync, vsync
  );

  modport slave (
    output pkt_valid,
    input  pkt_start, island_word, mode, ctl_ch0, ctl_ch1, ctl_ch2, cx, cy, hsync, vsync
  );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// Raster timing generator and HDMI period sequencer feeding three TMDS channel encoders.
// Every output is registered and refers to the position reported on cx/cy in the same cycle:
// the next position is computed combinationally and all outputs are registered from it.
// Build option: define HDMI_ISLAND_EN to enable data islands; without it the block is a plain
// DVI sequencer (no islands, pkt_start/island_word tied low, pkt_valid ignored).
module hdmi_period_scheduler #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned ISLAND_GAP = 4,
  parameter int unsigned MAX_PKTS   = 2
) (
  input logic                     clk_pixel,
  input logic                     reset_n,
  hdmi_period_scheduler_if.master bus
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] HLast    = 12'(HTotal - 1);
  localparam logic [11:0] VLast    = 12'(VTotal - 1);
  localparam logic [11:0] HAct     = 12'(H_ACTIVE);
  localparam logic [11:0] VAct     = 12'(V_ACTIVE);
  localparam logic [11:0] VActM1   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] HSyncLo  = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HSyncHi  = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VSyncLo  = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VSyncHi  = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [11:0] VPreLo   = 12'(HTotal - 10);
  localparam logic [11:0] VGuardLo = 12'(HTotal - 2);

  localparam logic [2:0] ModeCtrl    = 3'd0;
  localparam logic [2:0] ModeVideo   = 3'd1;
  localparam logic [2:0] ModeVGuard  = 3'd2;
  localparam logic [2:0] ModeIsland  = 3'd3;
  localparam logic [2:0] ModeIGuard  = 3'd4;

  // Parameter sanity: the island (preamble, guards, one packet, trailing control) must fit in
  // horizontal blanking ahead of the video preamble.
  if (H_FRONT + H_SYNC + H_BACK < ISLAND_GAP + 10 + 48) begin : g_err_blank
    $error("hdmi_period_scheduler: horizontal blanking too short for a data island");
  end
  if (MAX_PKTS < 1 || MAX_PKTS > 18) begin : g_err_pkts
    $error("hdmi_period_scheduler: MAX_PKTS must be within 1..18");
  end
  if (HTotal > 4096 || VTotal > 4096) begin : g_err_total
    $error("hdmi_period_scheduler: raster does not fit 12-bit cx/cy");
  end

`ifdef HDMI_ISLAND_EN
  typedef enum logic [2:0] {
    StCtrl, StVPre, StVGuard, StVideo, StIPre, StILGuard, StIData, StITGuard
  } st_e;

  localparam logic [11:0] IslandD      = 12'(H_ACTIVE + ISLAND_GAP);
  // Preamble 8 + guard 2 + packet 32 + guard 2 + 4 control cycles, ending by the video preamble.
  localparam bit          IslandFits   = (H_ACTIVE + ISLAND_GAP + 48 <= HTotal - 10);
  // A follow-on packet starting at nx needs 32 + 2 + 4 cycles before the video preamble.
  localparam logic [11:0] NextPktLimit = 12'(HTotal - 48);
  localparam logic [4:0]  MaxPkts      = 5'(MAX_PKTS);
`else
  typedef enum logic [1:0] {StCtrl, StVPre, StVGuard, StVideo} st_e;
`endif

  st_e         st_q, st_d, raster_st;
  logic [11:0] cx_q, cy_q, nx, ny;
  logic        next_line_active;
  logic        hs_q, vs_q, hs_d, vs_d;
  logic [2:0]  mode_q, mode_d;
  logic [1:0]  ctl1_q, ctl1_d, ctl2_q, ctl2_d;

`ifdef HDMI_ISLAND_EN
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] word_q, word_d;
  logic [4:0] npkt_q, npkt_d;
  logic       start_q, start_d;
`else
  logic unused_pkt_valid;
  assign unused_pkt_valid = bus.pkt_valid;
`endif

  // Next raster position.
  always_comb begin
    if (cx_q == HLast) begin
      nx = '0;
      ny = (cy_q == VLast) ? '0 : cy_q + 12'd1;
    end else begin
      nx = cx_q + 12'd1;
      ny = cy_q;
    end
  end

  // Period the raster alone dictates at the next position (video, video preamble/guard, control).
  always_comb begin
    next_line_active = (ny == VLast) || (ny < VActM1);
    if (nx < HAct && ny < VAct) begin
      raster_st = StVideo;
    end else if (next_line_active && nx >= VGuardLo) begin
      raster_st = StVGuard;
    end else if (next_line_active && nx >= VPreLo) begin
      raster_st = StVPre;
    end else begin
      raster_st = StCtrl;
    end
    hs_d = (nx >= HSyncLo && nx < HSyncHi) ? SYNC_POL : ~SYNC_POL;
    vs_d = (ny >= VSyncLo && ny < VSyncHi) ? SYNC_POL : ~SYNC_POL;
  end

  // Next FSM state: island sequencing overrides the raster once an island has been committed.
  always_comb begin
    st_d = raster_st;
`ifdef HDMI_ISLAND_EN
    cnt_d   = '0;
    word_d  = '0;
    npkt_d  = npkt_q;
    start_d = 1'b0;
    case (st_q)
      StIPre: begin
        if (cnt_q == 3'd7) begin
          st_d = StILGuard;
        end else begin
          st_d  = StIPre;
          cnt_d = cnt_q + 3'd1;
        end
      end
      StILGuard: begin
        if (cnt_q == 3'd1) begin
          st_d    = StIData;
          start_d = 1'b1;
          npkt_d  = 5'd1;
        end else begin
          st_d  = StILGuard;
          cnt_d = cnt_q + 3'd1;
        end
      end
      StIData: begin
        if (word_q == 5'd31) begin
          // Back-to-back packet without guard only if another is pending and still fits.
          if (bus.pkt_valid && npkt_q < MaxPkts && nx <= NextPktLimit) begin
            st_d    = StIData;
            start_d = 1'b1;
            npkt_d  = npkt_q + 5'd1;
          end else begin
            st_d = StITGuard;
          end
        end else begin
          st_d   = StIData;
          word_d = word_q + 5'd1;
        end
      end
      StITGuard: begin
        if (cnt_q != 3'd1) begin
          st_d  = StITGuard;
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        // No room at the decision point means this line is skipped; retried on the next one.
        if (IslandFits && nx == IslandD && bus.pkt_valid) begin
          st_d   = StIPre;
          npkt_d = '0;
        end
      end
    endcase
`endif
  end

  // Output decode for the next state; registered together with cx/cy.
  always_comb begin
    mode_d = ModeCtrl;
    ctl1_d = 2'b00;
    ctl2_d = 2'b00;
    case (st_d)
      StVideo:  mode_d = ModeVideo;
      StVGuard: mode_d = ModeVGuard;
      StVPre:   ctl1_d = 2'b01;
`ifdef HDMI_ISLAND_EN
      StIPre: begin
        ctl1_d = 2'b01;
        ctl2_d = 2'b01;
      end
      StILGuard, StITGuard: mode_d = ModeIGuard;
      StIData:              mode_d = ModeIsland;
`endif
      default: mode_d = ModeCtrl;
    endcase
  end

  // State, position and registered outputs.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= StCtrl;
      cx_q    <= '0;
      cy_q    <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      mode_q  <= ModeCtrl;
      ctl1_q  <= 2'b00;
      ctl2_q  <= 2'b00;
`ifdef HDMI_ISLAND_EN
      cnt_q   <= '0;
      word_q  <= '0;
      npkt_q  <= '0;
      start_q <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      cx_q    <= nx;
      cy_q    <= ny;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      mode_q  <= mode_d;
      ctl1_q  <= ctl1_d;
      ctl2_q  <= ctl2_d;
`ifdef HDMI_ISLAND_EN
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      npkt_q  <= npkt_d;
      start_q <= start_d;
`endif
    end
  end

  assign bus.cx      = cx_q;
  assign bus.cy      = cy_q;
  assign bus.hsync   = hs_q;
  assign bus.vsync   = vs_q;
  assign bus.mode    = mode_q;
  assign bus.ctl_ch0 = {vs_q, hs_q};
  assign bus.ctl_ch1 = ctl1_q;
  assign bus.ctl_ch2 = ctl2_q;
`ifdef HDMI_ISLAND_EN
  assign bus.pkt_start   = start_q;
  assign bus.island_word = word_q;
`else
  assign bus.pkt_start   = 1'b0;
  assign bus.island_word = 5'd0;
`endif

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler. Three instances share clock and reset:
//   a: 800-pixel lines, MAX_PKTS=1      b: 800-pixel lines, MAX_PKTS=2
//   c: 702-pixel lines (minimum blanking 62), room for only one packet per island
// Short 8-line frames (4 active, vsync on line 5) keep the run small. pkt_valid is held high.
module tb_hdmi_period_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdmi_period_scheduler_if if_a ();
  hdmi_period_scheduler_if if_b ();
  hdmi_period_scheduler_if if_c ();

  hdmi_period_scheduler #(
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .MAX_PKTS(1)
  ) dut_a (.clk_pixel(clk), .reset_n(rst_n), .bus(if_a));

  hdmi_period_scheduler #(
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .MAX_PKTS(2)
  ) dut_b (.clk_pixel(clk), .reset_n(rst_n), .bus(if_b));

  hdmi_period_scheduler #(
    .H_FRONT(8), .H_SYNC(30), .H_BACK(24),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .MAX_PKTS(2)
  ) dut_c (.clk_pixel(clk), .reset_n(rst_n), .bus(if_c));

`ifdef HDMI_ISLAND_EN
  localparam bit Isl = 1'b1;
`else
  localparam bit Isl = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected values as a function of raster position. Island sits at 644 (preamble 644..651,
  // guard 652..653, npk packets from 654, trailing guard), repeated on every line.
  function automatic bit nla(input int y);
    return (y == 7) || (y < 3);
  endfunction

  function automatic int exp_mode(input int x, input int y, input int ht, input int npk);
    int de;
    de = 654 + 32 * npk;
    if (x < 640 && y < 4) return 1;
    if (nla(y) && x >= ht - 2) return 2;
    if (Isl) begin
      if (x == 652 || x == 653 || x == de || x == de + 1) return 4;
      if (x >= 654 && x < de) return 3;
    end
    return 0;
  endfunction

  function automatic int exp_ctl1(input int x, input int y, input int ht);
    if (nla(y) && x >= ht - 10 && x <= ht - 3) return 1;
    if (Isl && x >= 644 && x <= 651) return 1;
    return 0;
  endfunction

  function automatic int exp_ctl2(input int x);
    return (Isl && x >= 644 && x <= 651) ? 1 : 0;
  endfunction

  function automatic int exp_start(input int x, input int npk);
    return (Isl && x >= 654 && x < 654 + 32 * npk && (x - 654) % 32 == 0) ? 1 : 0;
  endfunction

  function automatic int exp_word(input int x, input int npk);
    return (Isl && x >= 654 && x < 654 + 32 * npk) ? (x - 654) % 32 : 0;
  endfunction

  task automatic chk_dut(input string nm, input int x, input int y, input int ht, input int hf,
                         input int hsw, input int npk, input logic [11:0] cx,
                         input logic [11:0] cy, input logic [2:0] mode, input logic [1:0] c0,
                         input logic [1:0] c1, input logic [1:0] c2, input logic st,
                         input logic [4:0] wd);
    int hs, vs;
    hs = (x >= 640 + hf && x < 640 + hf + hsw) ? 0 : 1;
    vs = (y == 5) ? 0 : 1;
    chk({nm, " cx"}, 32'(cx), x);
    chk({nm, " cy"}, 32'(cy), y);
    chk({nm, " mode"}, 32'(mode), exp_mode(x, y, ht, npk));
    chk({nm, " ctl_ch0"}, 32'(c0), vs * 2 + hs);
    chk({nm, " ctl_ch1"}, 32'(c1), exp_ctl1(x, y, ht));
    chk({nm, " ctl_ch2"}, 32'(c2), exp_ctl2(x));
    chk({nm, " pkt_start"}, 32'(st), exp_start(x, npk));
    chk({nm, " island_word"}, 32'(wd), exp_word(x, npk));
  endtask

  task automatic chk_reset(input string nm, input logic [11:0] cx, input logic [11:0] cy,
                           input logic [2:0] mode, input logic [1:0] c0, input logic [1:0] c1,
                           input logic [1:0] c2, input logic st, input logic [4:0] wd,
                           input logic hs, input logic vs);
    chk({nm, " rst cx"}, 32'(cx), 0);
    chk({nm, " rst cy"}, 32'(cy), 0);
    chk({nm, " rst mode"}, 32'(mode), 0);
    chk({nm, " rst ctl_ch0"}, 32'(c0), 3);
    chk({nm, " rst ctl_ch1"}, 32'(c1), 0);
    chk({nm, " rst ctl_ch2"}, 32'(c2), 0);
    chk({nm, " rst pkt_start"}, 32'(st), 0);
    chk({nm, " rst island_word"}, 32'(wd), 0);
    chk({nm, " rst hsync"}, 32'(hs), 1);
    chk({nm, " rst vsync"}, 32'(vs), 1);
  endtask

  task automatic chk_all_reset();
    chk_reset("a", if_a.cx, if_a.cy, if_a.mode, if_a.ctl_ch0, if_a.ctl_ch1, if_a.ctl_ch2,
              if_a.pkt_start, if_a.island_word, if_a.hsync, if_a.vsync);
    chk_reset("b", if_b.cx, if_b.cy, if_b.mode, if_b.ctl_ch0, if_b.ctl_ch1, if_b.ctl_ch2,
              if_b.pkt_start, if_b.island_word, if_b.hsync, if_b.vsync);
    chk_reset("c", if_c.cx, if_c.cy, if_c.mode, if_c.ctl_ch0, if_c.ctl_ch1, if_c.ctl_ch2,
              if_c.pkt_start, if_c.island_word, if_c.hsync, if_c.vsync);
  endtask

  initial begin
    int xa, ya, xc, yc;
    bit found;
    if_a.pkt_valid = 1'b1;
    if_b.pkt_valid = 1'b1;
    if_c.pkt_valid = 1'b1;

    // Power-on reset.
    repeat (3) @(negedge clk);
    chk_all_reset();
    rst_n = 1'b1;

    // One full frame plus a bit, every position compared against the position model.
    xa = 0; ya = 0; xc = 0; yc = 0;
    for (int i = 0; i < 6500; i++) begin
      @(posedge clk);
      if (xa == 799) begin xa = 0; ya = (ya == 7) ? 0 : ya + 1; end
      else xa = xa + 1;
      if (xc == 701) begin xc = 0; yc = (yc == 7) ? 0 : yc + 1; end
      else xc = xc + 1;
      @(negedge clk);
      chk_dut("a", xa, ya, 800, 16, 96, 1, if_a.cx, if_a.cy, if_a.mode, if_a.ctl_ch0,
              if_a.ctl_ch1, if_a.ctl_ch2, if_a.pkt_start, if_a.island_word);
      chk_dut("b", xa, ya, 800, 16, 96, 2, if_b.cx, if_b.cy, if_b.mode, if_b.ctl_ch0,
              if_b.ctl_ch1, if_b.ctl_ch2, if_b.pkt_start, if_b.island_word);
      chk_dut("c", xc, yc, 702, 8, 30, 1, if_c.cx, if_c.cy, if_c.mode, if_c.ctl_ch0,
              if_c.ctl_ch1, if_c.ctl_ch2, if_c.pkt_start, if_c.island_word);
    end

    // Reset in the middle of a frame (inside the island on dut_a when islands are enabled).
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (if_a.cx == 12'd660) found = 1'b1;
    end
    chk("wait cx 660", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk_all_reset();
    repeat (2) @(negedge clk);
    chk_all_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release cx", 32'(if_a.cx), 1);
    chk("release mode", 32'(if_a.mode), 1);
    @(negedge clk);
    chk("release cx+1", 32'(if_a.cx), 2);
    chk("release cy", 32'(if_a.cy), 0);
    chk("release c cx", 32'(if_c.cx), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
